// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the ctrl_unit sequencer: FSM states, ALU op codes,
// instruction class/extension codes, mux selects and the instruction decoder.
package ctrl_pkg;

   typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_FAULT} state_t;
   typedef enum logic [2:0] {OP_ILL, OP_ALU, OP_JAL, OP_JCOND, OP_BCOND, OP_LOAD, OP_STOR} op_kind_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_CMP = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0011;
   localparam logic [3:0] ALU_OR  = 4'b0100;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_MOV = 4'b0110;
   localparam logic [3:0] ALU_LSH = 4'b0111;
   localparam logic [3:0] ALU_LUI = 4'b1000;

   // Arithmetic codes: register-class ext field and immediate-class opcode share them.
   localparam logic [3:0] OPC_AND = 4'b0001;
   localparam logic [3:0] OPC_OR  = 4'b0010;
   localparam logic [3:0] OPC_XOR = 4'b0011;
   localparam logic [3:0] OPC_ADD = 4'b0101;
   localparam logic [3:0] OPC_SUB = 4'b1001;
   localparam logic [3:0] OPC_CMP = 4'b1011;
   localparam logic [3:0] OPC_MOV = 4'b1101;
   localparam logic [3:0] OPC_LUI = 4'b1111;

   localparam logic [3:0] CLS_REG   = 4'b0000;
   localparam logic [3:0] CLS_SPEC  = 4'b0100;
   localparam logic [3:0] CLS_SHIFT = 4'b1000;
   localparam logic [3:0] CLS_BCOND = 4'b1100;

   localparam logic [3:0] EXT_LOAD    = 4'b0000;
   localparam logic [3:0] EXT_STOR    = 4'b0100;
   localparam logic [3:0] EXT_JAL     = 4'b1000;
   localparam logic [3:0] EXT_JCOND   = 4'b1100;
   localparam logic [3:0] EXT_LSH     = 4'b0100;
   localparam logic [2:0] EXT_LSHI_HI = 3'b000;

   localparam logic [1:0] PC_INC  = 2'd0;
   localparam logic [1:0] PC_DISP = 2'd1;
   localparam logic [1:0] PC_REG  = 2'd2;
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_PC   = 2'd2;

   typedef struct packed {
      op_kind_t   kind;
      logic [3:0] alu_op;
      logic       imm;
      logic       wr;
      logic       setf;
   } dec_t;

   localparam dec_t DEC_ILL = '{kind: OP_ILL, alu_op: 4'h0, imm: 1'b0, wr: 1'b0, setf: 1'b0};

   function automatic dec_t arith_dec(input logic [3:0] code, input logic imm);
      dec_t d;
      d = '{kind: OP_ALU, alu_op: ALU_ADD, imm: imm, wr: 1'b1, setf: 1'b0};
      case (code)
         OPC_ADD: d.setf = 1'b1;
         OPC_SUB: begin d.alu_op = ALU_SUB; d.setf = 1'b1; end
         OPC_CMP: begin d.alu_op = ALU_CMP; d.setf = 1'b1; d.wr = 1'b0; end
         OPC_AND: d.alu_op = ALU_AND;
         OPC_OR:  d.alu_op = ALU_OR;
         OPC_XOR: d.alu_op = ALU_XOR;
         OPC_MOV: d.alu_op = ALU_MOV;
         OPC_LUI: if (imm) d.alu_op = ALU_LUI; else d = DEC_ILL;
         default: d = DEC_ILL;
      endcase
      return d;
   endfunction

   function automatic dec_t decode(input logic [15:0] ins);
      dec_t d;
      d = DEC_ILL;
      case (ins[15:12])
         CLS_REG: d = arith_dec(ins[7:4], 1'b0);
         CLS_SPEC: begin
            case (ins[7:4])
               EXT_LOAD:  d.kind = OP_LOAD;
               EXT_STOR:  d.kind = OP_STOR;
               EXT_JAL:   d.kind = OP_JAL;
               EXT_JCOND: d.kind = OP_JCOND;
               default:   d = DEC_ILL;
            endcase
         end
         CLS_SHIFT: begin
            if (ins[7:4] == EXT_LSH)
               d = '{kind: OP_ALU, alu_op: ALU_LSH, imm: 1'b0, wr: 1'b1, setf: 1'b0};
            else if (ins[7:5] == EXT_LSHI_HI)
               d = '{kind: OP_ALU, alu_op: ALU_LSH, imm: 1'b1, wr: 1'b1, setf: 1'b0};
         end
         CLS_BCOND: d.kind = OP_BCOND;
         default: d = arith_dec(ins[15:12], 1'b1);
      endcase
      return d;
   endfunction

endpackage

// File: rtl/ctrl_unit_cond_eval.sv
// CR16 branch condition evaluation over PSR flags {F,L,N,C,Z}; purely combinational.
module cond_eval (
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       cond_true
);
   logic f, l, n, c, z;
   assign {f, l, n, c, z} = flags;

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'b0000: cond_true = z;
         4'b0001: cond_true = !z;
         4'b0010: cond_true = c;
         4'b0011: cond_true = !c;
         4'b0100: cond_true = l;
         4'b0101: cond_true = !l;
         4'b0110: cond_true = n;
         4'b0111: cond_true = !n;
         4'b1000: cond_true = f;
         4'b1001: cond_true = !f;
         4'b1010: cond_true = !z && !l;
         4'b1011: cond_true = z || l;
         4'b1100: cond_true = !z && !n;
         4'b1101: cond_true = z || n;
         4'b1110: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end
endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM control FSM with memory wait timeout into a sticky FAULT.
// Define CTRL_ILLEGAL_TRAP_EN to trap unrecognised encodings to FAULT instead of executing them as NOPs.
module ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int TO_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instruction,
   input  logic [4:0]  flags,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_load,
   output logic        pc_en,
   output logic [1:0]  pc_sel,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        imm_sel,
   output logic [3:0]  alu_op,
   output logic        flags_we,
   output logic        fault
);
   if (!((DATA_W == 16) || (DATA_W == 32)) || (TO_CYCLES < 1) || (TO_CYCLES > 255)) begin : g_param_check
      $error("ctrl_unit: DATA_W must be 16 or 32 and TO_CYCLES 1..255");
   end

   // The count that would reach TO_CYCLES on this waiting cycle triggers the timeout.
   localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

   state_t     state, next;
   logic [7:0] wait_cnt;
   dec_t       dec;
   logic       cond_true;
   logic       timeout;
   logic       unused_bits;

   assign dec         = decode(instruction);
   assign timeout     = !mem_ready && (wait_cnt == TO_LAST);
   assign unused_bits = ^instruction[3:0];

   cond_eval u_cond (
      .cond      (instruction[11:8]),
      .flags     (flags),
      .cond_true (cond_true)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_FETCH;
         wait_cnt <= 8'd0;
      end else begin
         state <= next;
         if ((state == ST_FETCH || state == ST_MEM) && next == state)
            wait_cnt <= wait_cnt + 8'd1;
         else
            wait_cnt <= 8'd0;
      end
   end

   always_comb begin
      next      = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_load   = 1'b0;
      pc_en     = 1'b0;
      pc_sel    = PC_INC;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      imm_sel   = 1'b0;
      alu_op    = 4'h0;
      flags_we  = 1'b0;
      fault     = 1'b0;
      // Reset overrides the registered state so an in-flight access is dropped immediately.
      if (reset) begin
         next    = ST_FETCH;
         mem_req = 1'b1;
      end else begin
         case (state)
            ST_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_load = 1'b1;
                  pc_en   = 1'b1;
                  next    = ST_DECODE;
               end else if (timeout) begin
                  next = ST_FAULT;
               end
            end
            ST_DECODE: begin
               case (dec.kind)
                  OP_ALU, OP_JAL, OP_JCOND, OP_BCOND: next = ST_EXEC;
                  OP_LOAD, OP_STOR:                   next = ST_MEM;
`ifdef CTRL_ILLEGAL_TRAP_EN
                  default: next = ST_FAULT;
`else
                  default: next = ST_FETCH;
`endif
               endcase
            end
            ST_EXEC: begin
               next = ST_FETCH;
               case (dec.kind)
                  OP_ALU: begin
                     alu_op    = dec.alu_op;
                     imm_sel   = dec.imm;
                     reg_write = dec.wr;
                     flags_we  = dec.setf;
                  end
                  OP_JAL: begin
                     reg_write = 1'b1;
                     wb_sel    = WB_PC;
                     pc_en     = 1'b1;
                     pc_sel    = PC_REG;
                  end
                  OP_JCOND: if (cond_true) begin
                     pc_en  = 1'b1;
                     pc_sel = PC_REG;
                  end
                  OP_BCOND: if (cond_true) begin
                     pc_en  = 1'b1;
                     pc_sel = PC_DISP;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = (dec.kind == OP_STOR);
               if (mem_ready) begin
                  if (dec.kind == OP_LOAD) begin
                     reg_write = 1'b1;
                     wb_sel    = WB_MEM;
                  end
                  next = ST_FETCH;
               end else if (timeout) begin
                  next = ST_FAULT;
               end
            end
            ST_FAULT: fault = 1'b1;
            default:  next = ST_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_ctrl_unit.sv
// Directed table-driven check of ctrl_unit, plus hand sequences for waits, timeout, traps and reset.
module tb_ctrl_unit;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instruction;
   logic [4:0]  flags;
   logic        mem_ready;
   logic        mem_req, mem_we, addr_sel, ir_load, pc_en, reg_write, imm_sel, flags_we, fault;
   logic [1:0]  pc_sel, wb_sel;
   logic [3:0]  alu_op;
   logic [16:0] outs;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ctrl_unit #(.DATA_W(16), .TO_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .instruction(instruction), .flags(flags), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load), .pc_en(pc_en),
      .pc_sel(pc_sel), .reg_write(reg_write), .wb_sel(wb_sel), .imm_sel(imm_sel), .alu_op(alu_op),
      .flags_we(flags_we), .fault(fault)
   );

   // {mem_req, mem_we, addr_sel, ir_load, pc_en, pc_sel, reg_write, wb_sel, imm_sel, alu_op, flags_we, fault}
   assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_en, pc_sel, reg_write, wb_sel, imm_sel,
                  alu_op, flags_we, fault};

   localparam logic [16:0] O_ZERO  = 17'b0_0_0_0_0_00_0_00_0_0000_0_0;
   localparam logic [16:0] O_FIDLE = 17'b1_0_0_0_0_00_0_00_0_0000_0_0;
   localparam logic [16:0] O_FRDY  = 17'b1_0_0_1_1_00_0_00_0_0000_0_0;
   localparam logic [16:0] O_FAULT = 17'b0_0_0_0_0_00_0_00_0_0000_0_1;
   localparam logic [16:0] O_MWAIT = 17'b1_0_1_0_0_00_0_00_0_0000_0_0;
   localparam logic [16:0] O_LOAD  = 17'b1_0_1_0_0_00_1_01_0_0000_0_0;
   localparam logic [16:0] O_STOR  = 17'b1_1_1_0_0_00_0_00_0_0000_0_0;
   localparam logic [16:0] O_JAL   = 17'b0_0_0_0_1_10_1_10_0_0000_0_0;
   localparam logic [16:0] O_JTAKE = 17'b0_0_0_0_1_10_0_00_0_0000_0_0;
   localparam logic [16:0] O_BTAKE = 17'b0_0_0_0_1_01_0_00_0_0000_0_0;

   function automatic logic [16:0] o_alu(input logic rw, input logic imm, input logic [3:0] op,
                                         input logic fwe);
      return {5'b00000, 2'b00, rw, 2'b00, imm, op, fwe, 1'b0};
   endfunction

   typedef struct {
      string       nm;
      logic [15:0] ins;
      logic [4:0]  fl;
      logic [16:0] exp;
   } vec_t;
   vec_t vt[$];

   // Inputs are already applied; sample at the falling edge, then move to just past the next rise.
   task automatic chk(input string nm, input logic [16:0] exp);
      @(negedge clk);
      n_vec++;
      if (outs !== exp) begin
         n_bad++;
         $display("FAIL %s: outputs %b, expected %b", nm, outs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      chk("reset_hold", O_FIDLE);
      reset = 1'b0;
   endtask

   task automatic fetch_decode(input string nm, input logic [15:0] ins, input logic [4:0] fl);
      instruction = ins;
      flags = fl;
      mem_ready = 1'b1;
      chk({nm, "_fetch"}, O_FRDY);
      chk({nm, "_decode"}, O_ZERO);
   endtask

   task automatic expect_timeout(input string nm);
      mem_ready = 1'b0;
      for (int i = 0; i < TO; i++) chk({nm, "_wait"}, O_FIDLE);
      chk({nm, "_fault"}, O_FAULT);
   endtask

   initial begin
      vt.push_back('{"add",    16'h0352, 5'b00000, o_alu(1'b1, 1'b0, 4'h0, 1'b1)});
      vt.push_back('{"sub",    16'h0391, 5'b00000, o_alu(1'b1, 1'b0, 4'h1, 1'b1)});
      vt.push_back('{"cmp",    16'h03B1, 5'b00000, o_alu(1'b0, 1'b0, 4'h2, 1'b1)});
      vt.push_back('{"and",    16'h0312, 5'b00000, o_alu(1'b1, 1'b0, 4'h3, 1'b0)});
      vt.push_back('{"or",     16'h0321, 5'b00000, o_alu(1'b1, 1'b0, 4'h4, 1'b0)});
      vt.push_back('{"xor",    16'h0331, 5'b00000, o_alu(1'b1, 1'b0, 4'h5, 1'b0)});
      vt.push_back('{"mov",    16'h03D1, 5'b00000, o_alu(1'b1, 1'b0, 4'h6, 1'b0)});
      vt.push_back('{"lsh",    16'h8342, 5'b00000, o_alu(1'b1, 1'b0, 4'h7, 1'b0)});
      vt.push_back('{"lshi1",  16'h8312, 5'b00000, o_alu(1'b1, 1'b1, 4'h7, 1'b0)});
      vt.push_back('{"lshi0",  16'h8302, 5'b00000, o_alu(1'b1, 1'b1, 4'h7, 1'b0)});
      vt.push_back('{"andi",   16'h1312, 5'b00000, o_alu(1'b1, 1'b1, 4'h3, 1'b0)});
      vt.push_back('{"ori",    16'h2312, 5'b00000, o_alu(1'b1, 1'b1, 4'h4, 1'b0)});
      vt.push_back('{"xori",   16'h3312, 5'b00000, o_alu(1'b1, 1'b1, 4'h5, 1'b0)});
      vt.push_back('{"addi",   16'h5312, 5'b00000, o_alu(1'b1, 1'b1, 4'h0, 1'b1)});
      vt.push_back('{"subi",   16'h9312, 5'b00000, o_alu(1'b1, 1'b1, 4'h1, 1'b1)});
      vt.push_back('{"cmpi",   16'hB312, 5'b00000, o_alu(1'b0, 1'b1, 4'h2, 1'b1)});
      vt.push_back('{"movi",   16'hD3FF, 5'b00000, o_alu(1'b1, 1'b1, 4'h6, 1'b0)});
      vt.push_back('{"lui",    16'hF3AB, 5'b00000, o_alu(1'b1, 1'b1, 4'h8, 1'b0)});
      vt.push_back('{"jal",    16'h4381, 5'b00000, O_JAL});
      vt.push_back('{"jeq_t",  16'h40C1, 5'b00001, O_JTAKE});
      vt.push_back('{"jeq_n",  16'h40C1, 5'b00000, O_ZERO});
      vt.push_back('{"beq_t",  16'hC012, 5'b00001, O_BTAKE});
      vt.push_back('{"beq_n",  16'hC012, 5'b00000, O_ZERO});
      vt.push_back('{"bne_t",  16'hC112, 5'b00000, O_BTAKE});
      vt.push_back('{"bcs_t",  16'hC212, 5'b00010, O_BTAKE});
      vt.push_back('{"bcc_n",  16'hC312, 5'b00010, O_ZERO});
      vt.push_back('{"bhi_t",  16'hC412, 5'b01000, O_BTAKE});
      vt.push_back('{"bls_n",  16'hC512, 5'b01000, O_ZERO});
      vt.push_back('{"bgt_t",  16'hC612, 5'b00100, O_BTAKE});
      vt.push_back('{"ble_n",  16'hC712, 5'b00100, O_ZERO});
      vt.push_back('{"bfs_t",  16'hC812, 5'b10000, O_BTAKE});
      vt.push_back('{"bfc_n",  16'hC912, 5'b10000, O_ZERO});
      vt.push_back('{"blo_t",  16'hCA12, 5'b00000, O_BTAKE});
      vt.push_back('{"blo_n",  16'hCA12, 5'b00001, O_ZERO});
      vt.push_back('{"bhs_t",  16'hCB12, 5'b00001, O_BTAKE});
      vt.push_back('{"blt_t",  16'hCC12, 5'b00000, O_BTAKE});
      vt.push_back('{"blt_n",  16'hCC12, 5'b00100, O_ZERO});
      vt.push_back('{"bge_t",  16'hCD12, 5'b00100, O_BTAKE});
      vt.push_back('{"buc_t",  16'hCE12, 5'b00000, O_BTAKE});
      vt.push_back('{"bnv_n",  16'hCF12, 5'b11111, O_ZERO});
      vt.push_back('{"load0",  16'h4302, 5'b00000, O_LOAD});
      vt.push_back('{"stor0",  16'h4342, 5'b00000, O_STOR});

      // Reset holds the FETCH decode even with memory claiming ready.
      reset = 1'b1;
      mem_ready = 1'b1;
      instruction = 16'h0000;
      flags = 5'b00000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", O_FIDLE);
      reset = 1'b0;

      // Each vector: FETCH(ready), DECODE, EXEC/MEM(ready), back in FETCH at cycle 3.
      foreach (vt[i]) begin
         fetch_decode(vt[i].nm, vt[i].ins, vt[i].fl);
         chk({vt[i].nm, "_exec"}, vt[i].exp);
         mem_ready = 1'b0;
         chk({vt[i].nm, "_back"}, O_FIDLE);
      end

      // LOAD with two MEM wait cycles: write-back only in the ready cycle.
      fetch_decode("load2", 16'h4302, 5'b00000);
      mem_ready = 1'b0;
      chk("load2_wait1", O_MWAIT);
      chk("load2_wait2", O_MWAIT);
      mem_ready = 1'b1;
      chk("load2_ready", O_LOAD);
      mem_ready = 1'b0;
      chk("load2_back", O_FIDLE);

      // Unrecognised encoding.
      fetch_decode("illegal", 16'h0070, 5'b00000);
      mem_ready = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk("illegal_c2", O_FAULT);
      chk("illegal_c3", O_FAULT);
`else
      chk("illegal_c2", O_FIDLE);
      chk("illegal_c3", O_FIDLE);
`endif
      do_reset();

      // FETCH timeout after exactly TO wait cycles; fault is sticky until reset.
      expect_timeout("to");
      chk("to_sticky1", O_FAULT);
      mem_ready = 1'b1;
      chk("to_sticky2", O_FAULT);
      do_reset();
      chk("to_after_rst", O_FIDLE);

      // Ready arriving on the last allowed wait cycle beats the timeout.
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < TO - 1; i++) chk("win_wait", O_FIDLE);
      instruction = 16'h0352;
      mem_ready = 1'b1;
      chk("win_fetch", O_FRDY);
      chk("win_decode", O_ZERO);
      chk("win_exec", o_alu(1'b1, 1'b0, 4'h0, 1'b1));

      // Reset during a STOR wait aborts the access and clears the wait counter.
      mem_ready = 1'b0;
      chk("stw_fetch_idle", O_FIDLE);
      fetch_decode("stw", 16'h4342, 5'b00000);
      mem_ready = 1'b0;
      chk("stw_wait", O_STOR);
      chk("stw_wait2", O_STOR);
      reset = 1'b1;
      chk("stw_reset", O_FIDLE);
      reset = 1'b0;
      expect_timeout("stw_cnt");
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
